// File: rtl/lfsr_stream_pkg.sv
// Shared types and the single-step LFSR helper for lfsr_stream.
// Exports: lfsr_state_t (FSM states), lfsr_vec_t, lfsr_step().
package lfsr_stream_pkg;

    typedef enum logic [0:0] {
        S_IDLE,
        S_RUN
    } lfsr_state_t;

    // Widest LFSR the helper supports; narrower registers are zero-extended.
    localparam int MAX_W = 64;

    typedef logic [MAX_W-1:0] lfsr_vec_t;

    // One Fibonacci step: the feedback enters at the top and the register
    // shifts toward bit 0. Bits at and above `width` must be zero on entry.
    function automatic lfsr_vec_t lfsr_step(
        input lfsr_vec_t state,
        input lfsr_vec_t taps,
        input int        width
    );
        lfsr_vec_t r;
        logic      fb;
        fb = ^(state & taps);
        r = state >> 1;
        r[width-1] = fb;
        return r;
    endfunction

endpackage

// File: rtl/lfsr_stream_if.sv
// Valid/ready stream bundle for lfsr_stream plus its control and status.
// master: the generator side; slave: the consumer/controller side.
interface lfsr_stream_if #(
    parameter int WIDTH = 16,
    parameter int BITS  = 4,
    parameter int CNT_W = 16
);
    logic             i_en;
    logic             i_seed_load;
    logic [WIDTH-1:0] i_seed;
    logic             i_ready;
    logic             o_valid;
    logic [BITS-1:0]  o_data;
    logic [CNT_W-1:0] o_count;
    logic             o_wrap;
    logic             o_lockup;

    modport master (
        input  i_en, i_seed_load, i_seed, i_ready,
        output o_valid, o_data, o_count, o_wrap, o_lockup
    );

    modport slave (
        output i_en, i_seed_load, i_seed, i_ready,
        input  o_valid, o_data, o_count, o_wrap, o_lockup
    );

endinterface

// File: rtl/lfsr_stream_next.sv
// Combinational advance of the LFSR by BITS single steps in one cycle.
// Ports: cur = present LFSR state, nxt = state after BITS steps.
module lfsr_stream_next
    import lfsr_stream_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'h6801,
    parameter int               BITS  = 4
) (
    input  logic [WIDTH-1:0] cur,
    output logic [WIDTH-1:0] nxt
);

    lfsr_vec_t v;
    logic      unused_hi;

    always_comb begin
        v = MAX_W'(cur);
        for (int i = 0; i < BITS; i++) begin
            v = lfsr_step(v, MAX_W'(TAPS), WIDTH);
        end
    end

    assign nxt = v[WIDTH-1:0];

    // Bits above WIDTH stay zero by construction.
    assign unused_hi = ^(v >> WIDTH);

endmodule

// File: rtl/lfsr_stream.sv
// Fibonacci LFSR random source emitting BITS bits per valid/ready transfer.
// Ports: i_clk, i_rst (async, active high), bus (lfsr_stream_if.master).
module lfsr_stream
    import lfsr_stream_pkg::*;
#(
    parameter int               WIDTH = 16,
    parameter logic [WIDTH-1:0] TAPS  = 16'h6801,
    parameter logic [WIDTH-1:0] SEED  = 16'hF733,
    parameter int               BITS  = 4,
    parameter int               CNT_W = 16
) (
    input logic          i_clk,
    input logic          i_rst,
    lfsr_stream_if.master bus
);

    lfsr_state_t      state;
    lfsr_state_t      state_nxt;
    logic [WIDTH-1:0] lfsr;
    logic [WIDTH-1:0] start;
    logic [WIDTH-1:0] adv;
    logic [WIDTH-1:0] load_val;
    logic [CNT_W-1:0] count;
    logic             wrap_q;
    logic             lockup_q;
    logic             valid;
    logic             xfer;
    logic             zero_seed;

    lfsr_stream_next #(
        .WIDTH(WIDTH),
        .TAPS (TAPS),
        .BITS (BITS)
    ) u_next (
        .cur(lfsr),
        .nxt(adv)
    );

    // An all-zero seed would lock the LFSR; substitute the default seed.
    assign zero_seed = (bus.i_seed == '0);
    assign load_val  = zero_seed ? SEED : bus.i_seed;

    always_comb begin
        state_nxt = state;
        valid     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.i_en) state_nxt = S_RUN;
            end
            S_RUN: begin
                // A load owns the cycle, so nothing is offered.
                valid = ~bus.i_seed_load;
                if (!bus.i_en) state_nxt = S_IDLE;
            end
        endcase
    end

    assign xfer = valid & bus.i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= S_IDLE;
            lfsr     <= SEED;
            start    <= SEED;
            count    <= '0;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            wrap_q   <= 1'b0;
            lockup_q <= 1'b0;
            if (bus.i_seed_load) begin
                lfsr     <= load_val;
                start    <= load_val;
                count    <= '0;
                lockup_q <= zero_seed;
            end else if (xfer) begin
                lfsr   <= adv;
                count  <= count + 1'b1;
                wrap_q <= (adv == start);
            end
        end
    end

    assign bus.o_valid  = valid;
    assign bus.o_data   = valid ? lfsr[BITS-1:0] : '0;
    assign bus.o_count  = count;
    assign bus.o_wrap   = wrap_q;
    assign bus.o_lockup = lockup_q;

endmodule

// File: tb/tb_lfsr_stream.sv
// Scoreboard bench for lfsr_stream: three configurations (4-bit BITS=1,
// 4-bit BITS=4, default 16-bit) driven by directed vectors.
module tb_lfsr_stream;

    typedef struct {
        logic [3:0]  d;
        logic [15:0] c;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   wrap_a;
    int   wrap_c;
    exp_t qa[$];
    exp_t qb[$];
    exp_t ea;
    exp_t eb;

    // x^4+x^3+1 right-shift sequence from state 1, hand-derived.
    logic [3:0] st [15] = '{4'h1, 4'h8, 4'h4, 4'h2, 4'h9, 4'hC, 4'h6,
                            4'hB, 4'h5, 4'hA, 4'hD, 4'hE, 4'hF, 4'h7, 4'h3};

    lfsr_stream_if #(.WIDTH(4),  .BITS(1), .CNT_W(16)) ia ();
    lfsr_stream_if #(.WIDTH(4),  .BITS(4), .CNT_W(16)) ib ();
    lfsr_stream_if #(.WIDTH(16), .BITS(1), .CNT_W(16)) ic ();

    lfsr_stream #(
        .WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .BITS(1), .CNT_W(16)
    ) u_a (
        .i_clk(clk), .i_rst(rst), .bus(ia)
    );

    lfsr_stream #(
        .WIDTH(4), .TAPS(4'h3), .SEED(4'h1), .BITS(4), .CNT_W(16)
    ) u_b (
        .i_clk(clk), .i_rst(rst), .bus(ib)
    );

    lfsr_stream #(
        .WIDTH(16), .TAPS(16'h6801), .SEED(16'hF733), .BITS(1), .CNT_W(16)
    ) u_c (
        .i_clk(clk), .i_rst(rst), .bus(ic)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_a(input int idx, input int cnt);
        exp_t e;
        e.d = {3'b000, st[idx % 15][0]};
        e.c = 16'(cnt);
        qa.push_back(e);
    endtask

    task automatic push_b(input int idx, input int cnt);
        exp_t e;
        e.d = st[idx % 15];
        e.c = 16'(cnt);
        qb.push_back(e);
    endtask

    // Monitor: every accepted word is compared against the scoreboard.
    always @(negedge clk) begin
        if (ia.o_valid && ia.i_ready) begin
            if (qa.size() == 0) begin
                check("a_unexpected_xfer", 32'd1, 32'd0);
            end else begin
                ea = qa.pop_front();
                check("a_data", 32'(ia.o_data), 32'(ea.d));
                check("a_count", 32'(ia.o_count), 32'(ea.c));
            end
        end
        if (ib.o_valid && ib.i_ready) begin
            if (qb.size() == 0) begin
                check("b_unexpected_xfer", 32'd1, 32'd0);
            end else begin
                eb = qb.pop_front();
                check("b_data", 32'(ib.o_data), 32'(eb.d));
                check("b_count", 32'(ib.o_count), 32'(eb.c));
            end
        end
        if (ia.o_wrap) wrap_a++;
        if (ic.o_wrap) wrap_c++;
    end

    initial begin
        checks = 0;
        failures = 0;
        wrap_a = 0;
        wrap_c = 0;
        rst = 1'b1;
        ia.i_en = 0; ia.i_seed_load = 0; ia.i_seed = '0; ia.i_ready = 0;
        ib.i_en = 0; ib.i_seed_load = 0; ib.i_seed = '0; ib.i_ready = 0;
        ic.i_en = 0; ic.i_seed_load = 0; ic.i_seed = '0; ic.i_ready = 0;
        repeat (2) tick();
        check("rst_a_valid", 32'(ia.o_valid), 0);
        check("rst_a_data", 32'(ia.o_data), 0);
        check("rst_a_count", 32'(ia.o_count), 0);
        check("rst_a_wrap", 32'(ia.o_wrap), 0);
        check("rst_a_lockup", 32'(ia.o_lockup), 0);
        rst = 1'b0;

        // BITS=1 full period from reset seed.
        ia.i_en = 1;
        ia.i_ready = 1;
        for (int k = 0; k < 15; k++) push_a(k, k);
        tick();
        repeat (15) tick();
        ia.i_ready = 0;
        #1;
        check("a_wrap_pulse", 32'(ia.o_wrap), 1);
        check("a_wrap_count", 32'(ia.o_count), 15);
        check("a_wrap_data", 32'(ia.o_data), 1);
        tick();
        check("a_wrap_once", 32'(wrap_a), 1);

        // Seed load of 6 while paused by the consumer.
        ia.i_seed_load = 1;
        ia.i_seed = 4'h6;
        #1;
        check("a_load_valid", 32'(ia.o_valid), 0);
        tick();
        ia.i_seed_load = 0;
        #1;
        check("a_load_lockup", 32'(ia.o_lockup), 0);
        check("a_load_count", 32'(ia.o_count), 0);
        check("a_load_data", 32'(ia.o_data), 0);
        for (int k = 0; k < 15; k++) push_a(6 + k, k);
        ia.i_ready = 1;
        repeat (15) tick();
        ia.i_ready = 0;
        #1;
        check("a_seed6_wrap", 32'(ia.o_wrap), 1);
        check("a_seed6_count", 32'(ia.o_count), 15);
        tick();
        check("a_seed6_wrap_end", 32'(ia.o_wrap), 0);
        check("a_wrap_total", 32'(wrap_a), 2);

        // Pause mid-stream: last transfer still counts, then frozen.
        for (int k = 0; k < 3; k++) push_a(6 + k, 15 + k);
        ia.i_ready = 1;
        repeat (2) tick();
        ia.i_en = 0;
        #1;
        check("a_pause_valid_last", 32'(ia.o_valid), 1);
        tick();
        check("a_pause_valid", 32'(ia.o_valid), 0);
        check("a_pause_count", 32'(ia.o_count), 18);
        repeat (2) tick();
        check("a_frozen_count", 32'(ia.o_count), 18);
        ia.i_en = 1;
        for (int k = 0; k < 2; k++) push_a(9 + k, 18 + k);
        tick();
        repeat (2) tick();
        ia.i_ready = 0;
        #1;
        check("a_resume_count", 32'(ia.o_count), 20);

        // BITS=4: four steps per transfer, then consumer back-pressure.
        ib.i_en = 1;
        ib.i_ready = 1;
        push_b(0, 0);
        push_b(4, 1);
        tick();
        repeat (2) tick();
        ib.i_ready = 0;
        #1;
        check("b_hold_data", 32'(ib.o_data), 5);
        check("b_hold_count", 32'(ib.o_count), 2);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("b_stall_data", 32'(ib.o_data), 5);
            check("b_stall_count", 32'(ib.o_count), 2);
        end

        // Zero seed while valid & ready: no transfer, lock-up recovery.
        ib.i_ready = 1;
        ib.i_seed_load = 1;
        ib.i_seed = 4'h0;
        #1;
        check("b_load_valid", 32'(ib.o_valid), 0);
        tick();
        ib.i_seed_load = 0;
        ib.i_ready = 0;
        #1;
        check("b_lockup", 32'(ib.o_lockup), 1);
        check("b_lockup_count", 32'(ib.o_count), 0);
        check("b_lockup_data", 32'(ib.o_data), 1);
        tick();
        check("b_lockup_end", 32'(ib.o_lockup), 0);
        push_b(0, 0);
        ib.i_ready = 1;
        tick();
        ib.i_ready = 0;
        #1;
        check("b_after_data", 32'(ib.o_data), 9);
        check("b_after_count", 32'(ib.o_count), 1);

        // Asynchronous reset between clock edges.
        #1;
        rst = 1'b1;
        #1;
        check("arst_b_valid", 32'(ib.o_valid), 0);
        check("arst_b_data", 32'(ib.o_data), 0);
        check("arst_b_count", 32'(ib.o_count), 0);
        check("arst_a_count", 32'(ia.o_count), 0);
        #1;
        rst = 1'b0;
        tick();
        check("arst_b_seed", 32'(ib.o_data), 1);
        check("arst_b_run", 32'(ib.o_valid), 1);

        // Default 16-bit generator: one wrap after 65535 transfers.
        ic.i_en = 1;
        ic.i_ready = 1;
        tick();
        repeat (65535) tick();
        ic.i_ready = 0;
        #1;
        check("c_wrap", 32'(ic.o_wrap), 1);
        check("c_count", 32'(ic.o_count), 32'hFFFF);
        check("c_data", 32'(ic.o_data), 1);
        tick();
        check("c_wrap_once", 32'(wrap_c), 1);

        check("a_queue_left", 32'(qa.size()), 0);
        check("b_queue_left", 32'(qb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
